regfile_write_arbiter: RTL and testbench

//   Shares the single register-file write port among NUM_SRC writeback sources
//   (ALU, load unit, CSR/mul-div). Grants one valid source per cycle, registers
//   the winning rd/data and drives the write port one cycle later. Drops writes
//   to x0 and counts cycles with write-port contention for performance analysis.

---
 rtl/regfile_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Shares the single register-file write port among NUM_SRC writeback
//   sources (ALU, load unit, CSR/mul-div). At most one valid source is
//   granted per cycle. The winning rd/data are registered and drive the
//   register-file write port one cycle after acceptance. Writes to x0 are
//   accepted but never enabled. A saturating counter records every cycle
//   in which two or more sources competed for the port.
//
// Configuration:
//   WB_ARB_ROUND_ROBIN_EN  defined   -> round-robin grant starting at the
//                                       rotating pointer (starvation-free)
//                          undefined -> fixed priority, lowest index wins;
//                                       no pointer register is built
//
// Parameters:
//   NUM_SRC     number of writeback sources (2..8)
//   REG_ADDR_W  register index width
//   DATA_W      register data width
//   CNT_W       contention counter width
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous, active-high reset
//   src_valid          per-source write pending
//   src_rd             per-source destination register, slice i = source i
//   src_data           per-source write data, slice i = source i
//   src_ready          one-hot combinational grant (transfer = valid & ready)
//   rf_write_register  register-file write address (registered)
//   rf_write_data      register-file write data (registered)
//   rf_write_enable    register-file write enable (registered)
//   conflict_count     saturating count of cycles with >= 2 valid sources
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [REG_ADDR_W-1:0]         rf_write_register,
    output logic [DATA_W-1:0]             rf_write_data,
    output logic                          rf_write_enable,
    output logic [CNT_W-1:0]              conflict_count
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]      w_basePtr;
    logic                  w_found;
    logic [PTR_W-1:0]      w_grantIdx;
    logic [NUM_SRC-1:0]    w_grant;
    logic [REG_ADDR_W-1:0] w_selRd;
    logic [DATA_W-1:0]     w_selData;
    logic                  w_contention;

    logic [REG_ADDR_W-1:0] r_wrReg;
    logic [DATA_W-1:0]     r_wrData;
    logic                  r_wrEn;
    logic [CNT_W-1:0]      r_conflictCnt;

    // Source index reached by stepping 'offset' places upward from 'base',
    // wrapping past NUM_SRC-1 back to 0.
    function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base,
                                                 input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return PTR_W'(sum);
    endfunction

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_rrPtr;

    assign w_basePtr = r_rrPtr;

    // The pointer moves to the slot just after the winner, so the winner
    // becomes the lowest priority on the next contested cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (w_found) begin
            r_rrPtr <= (w_grantIdx == PTR_W'(NUM_SRC - 1)) ? '0 : w_grantIdx + 1'b1;
        end
    end
`else
    // Fixed priority is the same search anchored permanently at source 0.
    assign w_basePtr = '0;
`endif

    // Search upward from the base pointer for the first valid source.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found && src_valid[wrapIdx(w_basePtr, k)]) begin
                w_found    = 1'b1;
                w_grantIdx = wrapIdx(w_basePtr, k);
            end
        end
    end

    assign w_grant   = w_found ? (NUM_SRC'(1) << w_grantIdx) : '0;
    assign src_ready = w_grant;

    // Select the winning source's rd/data using the one-hot grant.
    always_comb begin
        w_selRd   = '0;
        w_selData = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                w_selRd   = src_rd[i*REG_ADDR_W +: REG_ADDR_W];
                w_selData = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more
    // sources are valid at once.
    assign w_contention = |(src_valid & (src_valid - 1'b1));

    // Write-port stage: address/data hold when idle so the register file
    // only sees a change when a new write is accepted; x0 is never enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrReg  <= '0;
            r_wrData <= '0;
            r_wrEn   <= 1'b0;
        end else if (w_found) begin
            r_wrReg  <= w_selRd;
            r_wrData <= w_selData;
            r_wrEn   <= (w_selRd != '0);
        end else begin
            r_wrEn   <= 1'b0;
        end
    end

    // Contention counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflictCnt <= '0;
        end else if (w_contention && (r_conflictCnt != {CNT_W{1'b1}})) begin
            r_conflictCnt <= r_conflictCnt + 1'b1;
        end
    end

    assign rf_write_register = r_wrReg;
    assign rf_write_data     = r_wrData;
    assign rf_write_enable   = r_wrEn;
    assign conflict_count    = r_conflictCnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter (NUM_SRC=3, CNT_W=16). Each driven
// cycle pushes its hand-computed expectation (grant for this cycle, write
// port contents resulting from the previous cycle, contention count) into a
// scoreboard queue; an independent monitor pops and compares. Expectations
// follow round-robin order when WB_ARB_ROUND_ROBIN_EN is defined and fixed
// priority otherwise.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [2:0]  src_valid;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic [2:0]  src_ready;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic [15:0] conflict_count;

    logic [4:0]  rdArr[3];
    logic [31:0] dataArr[3];

    int compared;
    int mismatched;

    typedef struct {
        int          tag;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [15:0] cnt;
    } expT;

    expT sbQ[$];

    assign src_rd   = {rdArr[2], rdArr[1], rdArr[0]};
    assign src_data = {dataArr[2], dataArr[1], dataArr[0]};

    regfile_write_arbiter #(
        .NUM_SRC(3),
        .REG_ADDR_W(5),
        .DATA_W(32),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .src_valid(src_valid),
        .src_rd(src_rd),
        .src_data(src_data),
        .src_ready(src_ready),
        .rf_write_register(rf_write_register),
        .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .conflict_count(conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what should be
    // visible during that cycle.
    task automatic applyStimulus(input int tag, input logic [2:0] v,
                                 input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [2:0] eReady, input logic eWe, input logic [4:0] eRd,
                                 input logic [31:0] eData, input logic [15:0] eCnt);
        expT e;
        @(negedge clock);
        src_valid  = v;
        rdArr[0]   = r0;
        rdArr[1]   = r1;
        rdArr[2]   = r2;
        dataArr[0] = d0;
        dataArr[1] = d1;
        dataArr[2] = d2;
        e.tag   = tag;
        e.ready = eReady;
        e.we    = eWe;
        e.rd    = eRd;
        e.data  = eData;
        e.cnt   = eCnt;
        sbQ.push_back(e);
    endtask

    // Monitor: sample after the combinational grant settles, well clear of
    // the rising edge.
    initial begin
        expT e;
        forever begin
            @(negedge clock);
            #2;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput($sformatf("c%0d src_ready", e.tag), 32'(src_ready), 32'(e.ready));
                checkOutput($sformatf("c%0d rf_write_enable", e.tag), 32'(rf_write_enable), 32'(e.we));
                checkOutput($sformatf("c%0d rf_write_register", e.tag), 32'(rf_write_register), 32'(e.rd));
                checkOutput($sformatf("c%0d rf_write_data", e.tag), rf_write_data, e.data);
                checkOutput($sformatf("c%0d conflict_count", e.tag), 32'(conflict_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        src_valid  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rdArr[i]   = '0;
            dataArr[i] = '0;
        end

        #1;
        checkOutput("reset rf_write_enable", 32'(rf_write_enable), 32'h0);
        checkOutput("reset rf_write_register", 32'(rf_write_register), 32'h0);
        checkOutput("reset rf_write_data", rf_write_data, 32'h0);
        checkOutput("reset conflict_count", 32'(conflict_count), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Single source, then a write to x0 that is consumed but not enabled.
        applyStimulus(0, 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0,
                      3'b010, 1'b0, 5'd0, 32'h0, 16'd0);
        applyStimulus(1, 3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0,
                      3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 16'd0);
        applyStimulus(2, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      3'b000, 1'b0, 5'd0, 32'h1234, 16'd0);
        // Grant source 2 so the round-robin pointer wraps back to 0.
        applyStimulus(3, 3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h44,
                      3'b100, 1'b0, 5'd0, 32'h1234, 16'd0);

        // All three sources contend for six cycles.
        applyStimulus(4, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      3'b001, 1'b1, 5'd4, 32'h44, 16'd0);
        applyStimulus(5, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      RR ? 3'b010 : 3'b001, 1'b1, 5'd1, 32'h100, 16'd1);
        applyStimulus(6, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      RR ? 3'b100 : 3'b001, 1'b1, RR ? 5'd2 : 5'd1, RR ? 32'h200 : 32'h100, 16'd2);
        applyStimulus(7, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      3'b001, 1'b1, RR ? 5'd3 : 5'd1, RR ? 32'h300 : 32'h100, 16'd3);
        applyStimulus(8, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      RR ? 3'b010 : 3'b001, 1'b1, 5'd1, 32'h100, 16'd4);
        applyStimulus(9, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      RR ? 3'b100 : 3'b001, 1'b1, RR ? 5'd2 : 5'd1, RR ? 32'h200 : 32'h100, 16'd5);
        applyStimulus(10, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      3'b000, 1'b1, RR ? 5'd3 : 5'd1, RR ? 32'h300 : 32'h100, 16'd6);
        applyStimulus(11, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      3'b000, 1'b0, RR ? 5'd3 : 5'd1, RR ? 32'h300 : 32'h100, 16'd6);

        // Sources 0 and 2 both target x7; grant order decides the final value.
        applyStimulus(12, 3'b101, 5'd7, 5'd0, 5'd7, 32'hA, 32'h0, 32'hB,
                      3'b001, 1'b0, RR ? 5'd3 : 5'd1, RR ? 32'h300 : 32'h100, 16'd6);
        applyStimulus(13, 3'b101, 5'd7, 5'd0, 5'd7, 32'hA, 32'h0, 32'hB,
                      RR ? 3'b100 : 3'b001, 1'b1, 5'd7, 32'hA, 16'd7);
        applyStimulus(14, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      3'b000, 1'b1, 5'd7, RR ? 32'hB : 32'hA, 16'd8);
        applyStimulus(15, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      3'b000, 1'b0, 5'd7, RR ? 32'hB : 32'hA, 16'd8);

        // Reset asserted while a write is on the port.
        applyStimulus(16, 3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0,
                      3'b010, 1'b0, 5'd7, RR ? 32'hB : 32'hA, 16'd8);
        @(posedge clock);
        #3;
        checkOutput("pre-reset rf_write_enable", 32'(rf_write_enable), 32'h1);
        checkOutput("pre-reset rf_write_register", 32'(rf_write_register), 32'h9);
        reset = 1'b1;
        #1;
        checkOutput("async reset rf_write_enable", 32'(rf_write_enable), 32'h0);
        checkOutput("async reset rf_write_register", 32'(rf_write_register), 32'h0);
        checkOutput("async reset rf_write_data", rf_write_data, 32'h0);
        checkOutput("async reset conflict_count", 32'(conflict_count), 32'h0);
        @(negedge clock);
        src_valid = 3'b000;
        reset     = 1'b0;

        // Pointer must restart at source 0 after reset.
        applyStimulus(17, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300,
                      3'b001, 1'b0, 5'd0, 32'h0, 16'd0);
        applyStimulus(18, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                      3'b000, 1'b1, 5'd1, 32'h100, 16'd1);

        // Saturation: 65539 contended cycles since reset in total.
        @(negedge clock);
        src_valid = 3'b111;
        repeat (65533) @(posedge clock);
        #1;
        checkOutput("counter below saturation", 32'(conflict_count), 32'hFFFE);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("counter saturated", 32'(conflict_count), 32'hFFFF);
        @(negedge clock);
        src_valid = 3'b000;

        for (int i = 0; i < 20 && sbQ.size() > 0; i++) begin
            @(negedge clock);
        end
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
